// File: rtl/vga_scaled.sv
// vga_scaled: configurable VGA timing that integer-scales a DISP_W x DISP_H mono framebuffer,
// fetching one row per line into a line buffer. Define VGA_BORDER_EN for a 1-pixel image frame.
module vga_scaled #(
   parameter int unsigned H_SYNC    = 4,
   parameter int unsigned H_BACK    = 22,
   parameter int unsigned H_VISIBLE = 128,
   parameter int unsigned H_FRONT   = 11,
   parameter int unsigned V_SYNC    = 5,
   parameter int unsigned V_BACK    = 20,
   parameter int unsigned V_VISIBLE = 720,
   parameter int unsigned V_FRONT   = 5,
   parameter int unsigned DISP_W    = 64,
   parameter int unsigned DISP_H    = 32,
   parameter int unsigned SCALE_X   = 2,
   parameter int unsigned SCALE_Y   = 20,
   parameter int unsigned SYNC_NEG  = 1
) (
   input  logic                      pixel_clk_7_425mhz,
   input  logic                      rst,
   output logic                      fb_rd_req,
   output logic [$clog2(DISP_H)-1:0] fb_rd_row,
   input  logic                      fb_rd_valid,
   input  logic [DISP_W-1:0]         fb_rd_data,
   output logic                      color,
   output logic                      hsync,
   output logic                      vsync,
   output logic                      in_hblank,
   output logic                      in_vblank,
   output logic                      frame_start,
   output logic                      underrun
);
   localparam int unsigned H_TOTAL  = H_SYNC + H_BACK + H_VISIBLE + H_FRONT;
   localparam int unsigned V_TOTAL  = V_SYNC + V_BACK + V_VISIBLE + V_FRONT;
   localparam int unsigned H_OFF    = (H_VISIBLE - DISP_W * SCALE_X) / 2;
   localparam int unsigned V_OFF    = (V_VISIBLE - DISP_H * SCALE_Y) / 2;
   localparam int unsigned H_VIS0   = H_SYNC + H_BACK;
   localparam int unsigned V_VIS0   = V_SYNC + V_BACK;
   localparam int unsigned IMG_H0   = H_VIS0 + H_OFF;
   localparam int unsigned IMG_H1   = IMG_H0 + DISP_W * SCALE_X;
   localparam int unsigned IMG_V0   = V_VIS0 + V_OFF;
   localparam int unsigned IMG_V1   = IMG_V0 + DISP_H * SCALE_Y;
   localparam int unsigned DEADLINE = IMG_H0 - 2;
   localparam int unsigned HW       = $clog2(H_TOTAL);
   localparam int unsigned VW       = $clog2(V_TOTAL);
   localparam int unsigned SXW      = (SCALE_X > 1) ? $clog2(SCALE_X) : 1;
   localparam int unsigned SYW      = (SCALE_Y > 1) ? $clog2(SCALE_Y) : 1;
   localparam int unsigned CW       = (DISP_W > 1) ? $clog2(DISP_W) : 1;
   localparam int unsigned RW       = $clog2(DISP_H);
   localparam logic        SYNC_ACT = (SYNC_NEG == 0);

   if (DISP_W * SCALE_X > H_VISIBLE) begin : g_bad_w
      $error("vga_scaled: DISP_W*SCALE_X exceeds H_VISIBLE");
   end
   if (DISP_H * SCALE_Y > V_VISIBLE) begin : g_bad_h
      $error("vga_scaled: DISP_H*SCALE_Y exceeds V_VISIBLE");
   end
   if (H_SYNC + H_BACK + H_OFF < 4) begin : g_bad_lead
      $error("vga_scaled: too few clocks before the image to fetch a row");
   end

   logic [HW-1:0]     h;
   logic [VW-1:0]     v;
   logic [SXW-1:0]    sx;
   logic [SYW-1:0]    sy;
   logic [CW-1:0]     col;
   logic [RW-1:0]     row;
   logic [DISP_W-1:0] linebuf;
   logic              pending;
   logic              line_ok;

   logic h_last_c, v_last_c, h_img_c, v_img_c, h_vis_c, v_vis_c, pix_c;

   assign h_last_c = (h == HW'(H_TOTAL - 1));
   assign v_last_c = (v == VW'(V_TOTAL - 1));
   assign h_img_c  = (h >= HW'(IMG_H0)) && (h <= HW'(IMG_H1 - 1));
   assign v_img_c  = (v >= VW'(IMG_V0)) && (v <= VW'(IMG_V1 - 1));
   assign h_vis_c  = (h >= HW'(H_VIS0)) && (h <= HW'(H_VIS0 + H_VISIBLE - 1));
   assign v_vis_c  = (v >= VW'(V_VIS0)) && (v <= VW'(V_VIS0 + V_VISIBLE - 1));

   // Pixel for the current counter position; underrun lines keep line_ok low and stay black
   always_comb begin
      pix_c = h_img_c && v_img_c && line_ok && linebuf[CW'(DISP_W - 1) - col];
`ifdef VGA_BORDER_EN
      if (h_img_c && v_img_c &&
          (h == HW'(IMG_H0) || h == HW'(IMG_H1 - 1) || v == VW'(IMG_V0) || v == VW'(IMG_V1 - 1)))
         pix_c = 1'b1;
`endif
   end

   always_ff @(posedge pixel_clk_7_425mhz) begin
      if (rst) begin
         h           <= '0;
         v           <= '0;
         sx          <= '0;
         sy          <= '0;
         col         <= '0;
         row         <= '0;
         linebuf     <= '0;
         pending     <= 1'b0;
         line_ok     <= 1'b0;
         underrun    <= 1'b0;
         fb_rd_req   <= 1'b0;
         fb_rd_row   <= '0;
         color       <= 1'b0;
         hsync       <= ~SYNC_ACT;
         vsync       <= ~SYNC_ACT;
         in_hblank   <= 1'b1;
         in_vblank   <= 1'b1;
         frame_start <= 1'b0;
      end else begin
         // Raster position plus scaled row tracking, advanced once per line
         if (h_last_c) begin
            h <= '0;
            v <= v_last_c ? '0 : v + VW'(1);
            if (v_img_c) begin
               if (sy == SYW'(SCALE_Y - 1)) begin
                  sy  <= '0;
                  row <= (row == RW'(DISP_H - 1)) ? '0 : row + RW'(1);
               end else begin
                  sy <= sy + SYW'(1);
               end
            end else begin
               sy  <= '0;
               row <= '0;
            end
         end else begin
            h <= h + HW'(1);
         end

         if (h_img_c) begin
            if (sx == SXW'(SCALE_X - 1)) begin
               sx  <= '0;
               col <= (col == CW'(DISP_W - 1)) ? '0 : col + CW'(1);
            end else begin
               sx <= sx + SXW'(1);
            end
         end else begin
            sx  <= '0;
            col <= '0;
         end

         // One row fetch per image line; a missed deadline blanks the line and latches underrun
         fb_rd_req <= 1'b0;
         if (h == '0 && v_img_c) begin
            fb_rd_req <= 1'b1;
            fb_rd_row <= row;
            pending   <= 1'b1;
            line_ok   <= 1'b0;
         end else if (pending) begin
            if (fb_rd_valid) begin
               linebuf <= fb_rd_data;
               line_ok <= 1'b1;
               pending <= 1'b0;
            end else if (h == HW'(DEADLINE)) begin
               pending  <= 1'b0;
               underrun <= 1'b1;
            end
         end

         hsync       <= (h < HW'(H_SYNC)) ? SYNC_ACT : ~SYNC_ACT;
         vsync       <= (v < VW'(V_SYNC)) ? SYNC_ACT : ~SYNC_ACT;
         in_hblank   <= ~h_vis_c;
         in_vblank   <= ~v_vis_c;
         frame_start <= (h == '0) && (v == '0);
         color       <= pix_c;
      end
   end
endmodule

// File: tb/tb_vga_scaled.sv
// Directed bench for vga_scaled: default horizontal timing, shortened vertical timing
// (8 rows x4, 55-line frame) with a checkerboard framebuffer served at programmable latency.
`timescale 1ns/1ps
module tb_vga_scaled;
   localparam int HT  = 165;
   localparam int VT  = 55;
   localparam int F   = HT * VT;   // 9075 clocks per frame
   localparam int IH0 = 26;
   localparam int IH1 = 153;
   localparam int IV0 = 13;
   localparam int IV1 = 44;
   localparam int VV0 = 5;
   localparam int VV1 = 52;
`ifdef VGA_BORDER_EN
   localparam int ONES_F = 2206;
   localparam int EDGE1  = 1;
`else
   localparam int ONES_F = 2048;
   localparam int EDGE1  = 0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        fb_rd_req;
   logic [2:0]  fb_rd_row;
   logic        fb_rd_valid;
   logic [63:0] fb_rd_data;
   logic        color, hsync, vsync, in_hblank, in_vblank, frame_start, underrun;

   vga_scaled #(
      .V_SYNC(2), .V_BACK(3), .V_VISIBLE(48), .V_FRONT(2), .DISP_H(8), .SCALE_Y(4)
   ) dut (
      .pixel_clk_7_425mhz(clk),
      .rst(rst),
      .fb_rd_req(fb_rd_req),
      .fb_rd_row(fb_rd_row),
      .fb_rd_valid(fb_rd_valid),
      .fb_rd_data(fb_rd_data),
      .color(color),
      .hsync(hsync),
      .vsync(vsync),
      .in_hblank(in_hblank),
      .in_vblank(in_vblank),
      .frame_start(frame_start),
      .underrun(underrun)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   int pos      = 0;
   int lat      = 3;
   logic chk_color = 1'b1;

   int color_err = 0, sync_err = 0, blank_err = 0, req_err = 0, fs_err = 0;
   int fs_cnt, hs_low, vs_low, req_cnt, ones, line_ones, prev_line_ones;
   int m_q, m_idx, m_h, m_v, m_c, m_r;
   logic m_img, m_exp;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic wait_pos(input int target);
      int n;
      n = 0;
      while (pos != target && n < 20000) begin
         step();
         n++;
      end
      if (pos != target) check("wait_pos", 64'(pos), 64'(target));
   endtask

   task automatic clear_stats();
      fs_cnt = 0; hs_low = 0; vs_low = 0; req_cnt = 0; ones = 0;
   endtask

   // Counter index since reset release; output seen at a negedge reflects index pos-1
   always @(posedge clk) begin
      if (rst) pos <= 0;
      else     pos <= pos + 1;
   end

   // Framebuffer responder: row r is 0x5555.. for even r, 0xAAAA.. for odd r
   initial begin
      int   cnt;
      logic [2:0] rrow;
      logic [63:0] pat_even, pat_odd;
      pat_even = {32{2'b01}};
      pat_odd  = {32{2'b10}};
      cnt = 0;
      rrow = '0;
      fb_rd_valid = 1'b0;
      fb_rd_data  = '0;
      forever begin
         @(negedge clk);
         fb_rd_valid = 1'b0;
         if (cnt > 0) begin
            cnt--;
            if (cnt == 0) begin
               fb_rd_valid = 1'b1;
               fb_rd_data  = rrow[0] ? pat_odd : pat_even;
            end
         end
         if (fb_rd_req === 1'b1 && rst === 1'b0) begin
            cnt  = lat;
            rrow = fb_rd_row;
         end
      end
   end

   // Per-cycle expectations from raster position, plus statistics
   always @(negedge clk) begin
      if (rst === 1'b0 && pos >= 1) begin
         m_q   = pos - 1;
         m_idx = m_q % F;
         m_h   = m_idx % HT;
         m_v   = m_idx / HT;
         m_img = (m_h >= IH0 && m_h <= IH1 && m_v >= IV0 && m_v <= IV1);
         m_c   = (m_h - IH0) / 2;
         m_r   = (m_v - IV0) / 4;
         m_exp = m_img && ((m_c % 2) != (m_r % 2));
`ifdef VGA_BORDER_EN
         if (m_img && (m_h == IH0 || m_h == IH1 || m_v == IV0 || m_v == IV1)) m_exp = 1'b1;
`endif
         if (chk_color && color !== m_exp) color_err++;
         if (hsync !== !(m_h < 4) || vsync !== !(m_v < 2)) sync_err++;
         if (in_hblank !== !(m_h >= IH0 && m_h <= IH1) || in_vblank !== !(m_v >= VV0 && m_v <= VV1))
            blank_err++;
         if (frame_start === 1'b1) begin
            fs_cnt++;
            if (m_idx != 0) fs_err++;
         end else if (m_idx == 0) begin
            fs_err++;
         end
         if (hsync === 1'b0) hs_low++;
         if (vsync === 1'b0) vs_low++;
         if (fb_rd_req === 1'b1) begin
            req_cnt++;
            if (m_h != 0 || m_v < IV0 || m_v > IV1 || int'(fb_rd_row) != m_r) req_err++;
         end
         if (m_h == 0) line_ones = 0;
         if (color === 1'b1) begin
            ones++;
            line_ones++;
         end
         if (m_h == HT - 1) prev_line_ones = line_ones;
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int b;
      rst = 1'b1;
      clear_stats();
      repeat (4) step();
      check("rst_color", color, 0);
      check("rst_req", fb_rd_req, 0);
      check("rst_hblank", in_hblank, 1);
      check("rst_vblank", in_vblank, 1);
      check("rst_fs", frame_start, 0);
      check("rst_hsync", hsync, 1);
      check("rst_vsync", vsync, 1);
      check("rst_urun", underrun, 0);

      // Two free-running frames, latency 3
      rst = 1'b0;
      step();
      check("fs_first", frame_start, 1);
      check("hs_at_h0", hsync, 0);
      step();
      check("fs_one_cycle", frame_start, 0);
      wait_pos(2 * F);
      check("fs_count", 64'(fs_cnt), 2);
      check("hs_low", 64'(hs_low), 2 * 4 * VT);
      check("vs_low", 64'(vs_low), 2 * 2 * HT);
      check("req_count", 64'(req_cnt), 2 * 32);
      check("ones", 64'(ones), 2 * ONES_F);
      check("urun_clean", underrun, 0);

      // Deadline boundary: latency 23 on v=20 is in time, 24 on v=21 and 30 on v=22 are late
      b = 2 * F;
      wait_pos(b + 20 * HT); lat = 23;
      wait_pos(b + 20 * HT + 2); lat = 3;
      wait_pos(b + 21 * HT); lat = 24; chk_color = 1'b0;
      check("ln20_ones", 64'(prev_line_ones), 64 + EDGE1);
      check("urun_lat23", underrun, 0);
      wait_pos(b + 21 * HT + 2); lat = 3;
      wait_pos(b + 21 * HT + 20);
      check("urun_pre_deadline", underrun, 0);
      wait_pos(b + 21 * HT + 30);
      check("urun_lat24", underrun, 1);
      wait_pos(b + 22 * HT); lat = 30;
      check("ln21_black", 64'(prev_line_ones), 2 * EDGE1);
      wait_pos(b + 22 * HT + 2); lat = 3;
      wait_pos(b + 23 * HT); chk_color = 1'b1;
      check("ln22_black", 64'(prev_line_ones), 2 * EDGE1);
      wait_pos(b + 24 * HT);
      check("ln23_recover", 64'(prev_line_ones), 64 + EDGE1);
      wait_pos(3 * F + 5);
      check("urun_sticky", underrun, 1);

      // One-cycle reset mid-fetch at h=20, v=30; the pre-reset response lands after the new deadline
      b = 3 * F;
      wait_pos(b + 30 * HT); lat = 60;
      wait_pos(b + 30 * HT + 2); lat = 3;
      wait_pos(b + 30 * HT + 20);
      rst = 1'b1;
      step();
      check("mrst_color", color, 0);
      check("mrst_req", fb_rd_req, 0);
      check("mrst_hblank", in_hblank, 1);
      check("mrst_vblank", in_vblank, 1);
      check("mrst_fs", frame_start, 0);
      check("mrst_hsync", hsync, 1);
      check("mrst_vsync", vsync, 1);
      check("mrst_urun", underrun, 0);
      clear_stats();
      rst = 1'b0;
      step();
      check("mrst_fs_pulse", frame_start, 1);
      check("mrst_vsync_act", vsync, 0);
      step();
      check("mrst_fs_end", frame_start, 0);
      wait_pos(120);
      check("late_valid_ignored", underrun, 0);
      wait_pos(F);
      check("f2_fs_count", 64'(fs_cnt), 1);
      check("f2_req_count", 64'(req_cnt), 32);
      check("f2_ones", 64'(ones), ONES_F);
      check("f2_hs_low", 64'(hs_low), 4 * VT);
      check("f2_urun", underrun, 0);

      check("color_err", 64'(color_err), 0);
      check("sync_err", 64'(sync_err), 0);
      check("blank_err", 64'(blank_err), 0);
      check("req_err", 64'(req_err), 0);
      check("fs_err", 64'(fs_err), 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
